hart_mem_arbiter: RTL and testbench
===================================

# hart_mem_arbiter

Round-robin arbiter sharing the single memory/MMU port of the RV cluster between `N_HARTS` cores. It replaces the free-running hart selector with a request/grant handshake. A granted hart holds the port until its memory transaction completes. Harts in an atomic or CSR sequence can lock the port across transactions. Sits between the per-hart core/MMU pairs and the cluster output mux; `r_sel` drives that mux.

## Interface
Parameters:
- `N_HARTS`, default 2: number of requesting harts (≥2).
- `MAX_GRANT_CYCLES`, default 64: cycles a grant may be held without `w_done` before `r_timeout` sets.

Ports:
- `CLK`  in  1  sole clock; all state on rising edge.
- `RST_X`  in  1  asynchronous, active-low reset; clears all state immediately.
- `w_req`  in  N_HARTS  per-hart memory request, level; held until served.
- `w_lock`  in  N_HARTS  per-hart lock; keeps the grant across consecutive transactions.
- `w_done`  in  1  single-cycle pulse from memory controller: granted transaction finished.
- `w_busy`  in  1  memory controller busy.
- `w_mode_is_cpu`  in  1  controller in CPU mode; new grants only when 1.
- `w_next_mode_is_mc`  in  1  controller about to enter MC mode; blocks new grants.
- `r_grant`  out  N_HARTS  one-hot grant, registered; all-zero when no grant.
- `r_sel`  out  $clog2(N_HARTS)  index of granted or last-granted hart, registered.
- `r_valid`  out  1  a grant is active (equals `|r_grant`).
- `w_core_busy`  out  N_HARTS  per-hart busy: `w_busy` for the granted hart, 1 for all others and when `r_valid`=0.
- `r_timeout`  out  1  sticky flag: a grant exceeded `MAX_GRANT_CYCLES`.

## Operation
- States: IDLE, GRANT, SWITCH (2-bit encoding).
- Reset values: state IDLE, `r_grant`=0, `r_valid`=0, `r_sel`=0, priority pointer `r_last`=N_HARTS-1 (hart 0 has first priority), cycle counter=0, `r_timeout`=0.
- Arbitration (IDLE and SWITCH only):
  - Enable condition: `w_mode_is_cpu` && !`w_next_mode_is_mc` && |`w_req`.
  - Winner: first requesting hart scanning `r_last`+1, `r_last`+2, … with mod-N_HARTS wrap.
  - On the next edge: `r_grant`=onehot(winner), `r_sel`=winner, `r_valid`=1, counter=0, state GRANT.
  - Enable false: stay IDLE (from SWITCH, go to IDLE).
- GRANT:
  - `w_done` && `w_lock[r_sel]` && `w_req[r_sel]`: stay GRANT, counter=0, `r_last` unchanged (locked burst).
  - `w_done`, otherwise: `r_last`=`r_sel`, `r_grant`=0, `r_valid`=0, state SWITCH.
  - No `w_done`, `w_req[r_sel]`=0, `w_busy`=0: abandon. Release as above but `r_last` unchanged; go to IDLE.
  - Otherwise hold; counter increments and saturates at MAX_GRANT_CYCLES. When it reaches MAX_GRANT_CYCLES, `r_timeout`←1. The grant is never revoked by timeout.
- `w_mode_is_cpu`/`w_next_mode_is_mc` never revoke an active grant; they only block new ones.
- `r_sel` holds its value after release, so the output mux stays stable.
- Counter width is $clog2(MAX_GRANT_CYCLES+1).

## Timing
- Request latency: `w_req` sampled high in IDLE at edge k → `r_grant` visible after edge k; the hart sees a 1-cycle response.
- Back-to-back handoff: `w_done` at edge e → SWITCH after e, with a 1-cycle bubble and `r_grant`=0 → next grant visible after edge e+1.
- Locked burst: no bubble; `r_grant` stays constant across `w_done`.
- `w_done` sampled in IDLE or SWITCH is ignored.
- `w_done` and `w_req[r_sel]` falling in the same cycle: `w_done` wins, giving a normal release.
- `w_core_busy` is combinational from `r_grant` and `w_busy`; no added latency.
- `RST_X` low mid-grant: outputs return to reset values without waiting for a clock edge. After deassertion, the first edge arbitrates from hart 0.

## Test plan
- Reset then a single request: `w_req`=2'b01 → `r_grant`=01 one edge later. `w_done` → `r_grant`=00 for exactly 1 cycle, then 01 again if still requesting.
- Fairness: N_HARTS=2, `w_req`=11 held, `w_done` pulsed 3 cycles after each grant → grants alternate 01,10,01,10. Each grant is separated by one zero-grant cycle.
- Lock: hart 1 granted with `w_lock[1]`=1 over 3 `w_done` pulses while hart 0 also requests → `r_grant`=10 continuously. After `w_lock` drops, the next `w_done` hands off to hart 0 after 1 bubble.
- Mode gating: `w_next_mode_is_mc`=1 with `w_req`=11 in IDLE → no grant. Asserting it during an active grant → grant held until `w_done`, then no new grant.
- Timeout: MAX_GRANT_CYCLES=4, grant held with no `w_done` → `r_timeout`=1 after the 4th GRANT cycle, grant still active. `r_timeout` stays 1 after a later `w_done` until reset.
- Async reset mid-grant plus abandon: `RST_X` low between edges → `r_grant`=0 immediately. Separately, dropping `w_req[r_sel]` while `w_busy`=0 → release to IDLE with `r_last` unchanged.

Source files
------------

// File: rtl/hart_mem_arbiter.sv
// rtl/hart_mem_arbiter.sv - round-robin request/grant arbiter for the shared hart memory/MMU port
// A grant is held until w_done (or lock-extended); r_sel stays on the last granted hart after release.
module hart_mem_arbiter #(
    parameter int N_HARTS          = 2,
    parameter int MAX_GRANT_CYCLES = 64
) (
    input  logic                       CLK,
    input  logic                       RST_X,
    input  logic [N_HARTS-1:0]         w_req,
    input  logic [N_HARTS-1:0]         w_lock,
    input  logic                       w_done,
    input  logic                       w_busy,
    input  logic                       w_mode_is_cpu,
    input  logic                       w_next_mode_is_mc,
    output logic [N_HARTS-1:0]         r_grant,
    output logic [$clog2(N_HARTS)-1:0] r_sel,
    output logic                       r_valid,
    output logic [N_HARTS-1:0]         w_core_busy,
    output logic                       r_timeout
);

    localparam int SW = $clog2(N_HARTS);
    localparam int CW = $clog2(MAX_GRANT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_GRANT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_SWITCH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N_HARTS-1:0]  grant_q, grant_d;
    logic                valid_q, valid_d;
    logic [SW-1:0]       sel_q, sel_d;
    logic [SW-1:0]       last_q, last_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                timeout_q, timeout_d;

    logic                arb_en;
    logic                win_found;
    logic [SW-1:0]       win_idx;
    int                  scan_idx;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            sel_q     <= '0;
            last_q    <= SW'(N_HARTS - 1);
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Scan starts one past the last served hart so every requester is reached within N_HARTS grants.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int i = 1; i <= N_HARTS; i++) begin
            scan_idx = (int'(last_q) + i) % N_HARTS;
            if (!win_found && w_req[scan_idx[SW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[SW-1:0];
            end
        end
        arb_en = w_mode_is_cpu && !w_next_mode_is_mc && win_found;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE, S_SWITCH: begin
                if (arb_en) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    sel_d            = win_idx;
                    valid_d          = 1'b1;
                    cnt_d            = '0;
                    state_d          = S_GRANT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                if (w_done) begin
                    if (w_lock[sel_q] && w_req[sel_q]) begin
                        cnt_d = '0;
                    end else begin
                        last_d  = sel_q;
                        grant_d = '0;
                        valid_d = 1'b0;
                        state_d = S_SWITCH;
                    end
                end else if (!w_req[sel_q] && !w_busy) begin
                    // Abandoned request: pointer untouched so the hart keeps its turn.
                    grant_d = '0;
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_d == CNT_MAX) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                grant_d = '0;
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        r_grant   = grant_q;
        r_sel     = sel_q;
        r_valid   = valid_q;
        r_timeout = timeout_q;
        for (int h = 0; h < N_HARTS; h++) begin
            w_core_busy[h] = (valid_q && grant_q[h]) ? w_busy : 1'b1;
        end
    end

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// tb/tb_hart_mem_arbiter.sv - directed self-checking bench for hart_mem_arbiter
module tb_hart_mem_arbiter;

    logic       CLK;
    logic       RST_X;
    logic [1:0] w_req;
    logic [1:0] w_lock;
    logic       w_done;
    logic       w_busy;
    logic       w_mode_is_cpu;
    logic       w_next_mode_is_mc;
    logic [1:0] r_grant;
    logic       r_sel;
    logic       r_valid;
    logic [1:0] w_core_busy;
    logic       r_timeout;

    int checks = 0;
    int errors = 0;

    hart_mem_arbiter #(
        .N_HARTS(2),
        .MAX_GRANT_CYCLES(4)
    ) dut (
        .CLK(CLK),
        .RST_X(RST_X),
        .w_req(w_req),
        .w_lock(w_lock),
        .w_done(w_done),
        .w_busy(w_busy),
        .w_mode_is_cpu(w_mode_is_cpu),
        .w_next_mode_is_mc(w_next_mode_is_mc),
        .r_grant(r_grant),
        .r_sel(r_sel),
        .r_valid(r_valid),
        .w_core_busy(w_core_busy),
        .r_timeout(r_timeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        w_req = 2'b00;
        w_lock = 2'b00;
        w_done = 1'b0;
        w_busy = 1'b0;
        w_mode_is_cpu = 1'b1;
        w_next_mode_is_mc = 1'b0;
        RST_X = 1'b0;
        step();
        RST_X = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (r_grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", r_grant); end
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", r_valid); end
        checks++; if (r_sel !== 1'b0) begin errors++; $display("FAIL reset_sel got %b exp 0", r_sel); end
        checks++; if (r_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", r_timeout); end
        checks++; if (w_core_busy !== 2'b11) begin errors++; $display("FAIL reset_core_busy got %b exp 11", w_core_busy); end
    endtask

    task automatic test_single();
        do_reset();
        w_req = 2'b01;
        step();
        checks++; if (r_grant !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", r_grant); end
        checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", r_valid); end
        checks++; if (w_core_busy !== 2'b10) begin errors++; $display("FAIL single_core_busy got %b exp 10", w_core_busy); end
        w_busy = 1'b1;
        #1;
        checks++; if (w_core_busy !== 2'b11) begin errors++; $display("FAIL single_core_busy_comb got %b exp 11", w_core_busy); end
        step();
        step();
        w_done = 1'b1;
        step();
        w_done = 1'b0;
        checks++; if (r_grant !== 2'b00) begin errors++; $display("FAIL single_bubble got %b exp 00", r_grant); end
        step();
        checks++; if (r_grant !== 2'b01) begin errors++; $display("FAIL single_regrant got %b exp 01", r_grant); end
        // done and request drop together: normal release into SWITCH then IDLE
        w_done = 1'b1;
        w_req = 2'b00;
        step();
        w_done = 1'b0;
        step();
        checks++; if (r_grant !== 2'b00) begin errors++; $display("FAIL single_release got %b exp 00", r_grant); end
        w_done = 1'b1;
        step();
        w_done = 1'b0;
        checks++; if (r_grant !== 2'b00 || r_valid !== 1'b0) begin errors++; $display("FAIL idle_done_ignored got %b/%b exp 00/0", r_grant, r_valid); end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_g [4];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        do_reset();
        w_req = 2'b11;
        w_busy = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            checks++; if (r_grant !== exp_g[k]) begin errors++; $display("FAIL fair_grant%0d got %b exp %b", k, r_grant, exp_g[k]); end
            step();
            step();
            w_done = 1'b1;
            step();
            w_done = 1'b0;
            checks++; if (r_grant !== 2'b00) begin errors++; $display("FAIL fair_bubble%0d got %b exp 00", k, r_grant); end
            step();
        end
    endtask

    task automatic test_lock();
        do_reset();
        w_req = 2'b10;
        w_lock = 2'b10;
        w_busy = 1'b1;
        step();
        checks++; if (r_grant !== 2'b10) begin errors++; $display("FAIL lock_first got %b exp 10", r_grant); end
        w_req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            step();
            w_done = 1'b1;
            step();
            w_done = 1'b0;
            checks++; if (r_grant !== 2'b10) begin errors++; $display("FAIL lock_burst%0d got %b exp 10", k, r_grant); end
        end
        w_lock = 2'b00;
        step();
        w_done = 1'b1;
        step();
        w_done = 1'b0;
        checks++; if (r_grant !== 2'b00) begin errors++; $display("FAIL lock_bubble got %b exp 00", r_grant); end
        step();
        checks++; if (r_grant !== 2'b01) begin errors++; $display("FAIL lock_handoff got %b exp 01", r_grant); end
    endtask

    task automatic test_mode_gating();
        do_reset();
        w_next_mode_is_mc = 1'b1;
        w_req = 2'b11;
        w_busy = 1'b1;
        step();
        step();
        checks++; if (r_grant !== 2'b00 || r_valid !== 1'b0) begin errors++; $display("FAIL mode_blocked got %b/%b exp 00/0", r_grant, r_valid); end
        w_next_mode_is_mc = 1'b0;
        step();
        checks++; if (r_grant !== 2'b01) begin errors++; $display("FAIL mode_grant got %b exp 01", r_grant); end
        w_next_mode_is_mc = 1'b1;
        step();
        step();
        checks++; if (r_grant !== 2'b01) begin errors++; $display("FAIL mode_held got %b exp 01", r_grant); end
        w_done = 1'b1;
        step();
        w_done = 1'b0;
        step();
        checks++; if (r_grant !== 2'b00) begin errors++; $display("FAIL mode_no_new got %b exp 00", r_grant); end
        w_next_mode_is_mc = 1'b0;
        w_mode_is_cpu = 1'b0;
        step();
        checks++; if (r_grant !== 2'b00) begin errors++; $display("FAIL mode_not_cpu got %b exp 00", r_grant); end
        w_mode_is_cpu = 1'b1;
        step();
        checks++; if (r_grant !== 2'b10 || r_sel !== 1'b1) begin errors++; $display("FAIL mode_resume got %b sel %b exp 10 sel 1", r_grant, r_sel); end
    endtask

    task automatic test_timeout();
        do_reset();
        w_req = 2'b01;
        w_busy = 1'b1;
        step();
        checks++; if (r_timeout !== 1'b0) begin errors++; $display("FAIL to_start got %b exp 0", r_timeout); end
        step(); step(); step();
        checks++; if (r_timeout !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", r_timeout); end
        step();
        checks++; if (r_timeout !== 1'b1) begin errors++; $display("FAIL to_set got %b exp 1", r_timeout); end
        checks++; if (r_grant !== 2'b01) begin errors++; $display("FAIL to_grant_kept got %b exp 01", r_grant); end
        step(); step();
        w_done = 1'b1;
        step();
        w_done = 1'b0;
        checks++; if (r_grant !== 2'b00 || r_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %b/%b exp 00/1", r_grant, r_timeout); end
        step();
        step();
        checks++; if (r_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky_late got %b exp 1", r_timeout); end
    endtask

    task automatic test_async_reset_abandon();
        checks++; if (r_grant !== 2'b01) begin errors++; $display("FAIL ar_pre got %b exp 01", r_grant); end
        #3;
        RST_X = 1'b0;
        #1;
        checks++; if (r_grant !== 2'b00 || r_valid !== 1'b0) begin errors++; $display("FAIL ar_immediate got %b/%b exp 00/0", r_grant, r_valid); end
        checks++; if (r_timeout !== 1'b0 || r_sel !== 1'b0) begin errors++; $display("FAIL ar_flags got %b/%b exp 0/0", r_timeout, r_sel); end
        w_req = 2'b11;
        #1;
        RST_X = 1'b1;
        step();
        checks++; if (r_grant !== 2'b01) begin errors++; $display("FAIL ar_first_hart0 got %b exp 01", r_grant); end
        w_req = 2'b10;
        w_busy = 1'b1;
        step();
        checks++; if (r_grant !== 2'b01) begin errors++; $display("FAIL ab_busy_hold got %b exp 01", r_grant); end
        w_busy = 1'b0;
        step();
        checks++; if (r_grant !== 2'b00 || r_sel !== 1'b0) begin errors++; $display("FAIL ab_release got %b sel %b exp 00 sel 0", r_grant, r_sel); end
        w_req = 2'b11;
        w_busy = 1'b1;
        step();
        checks++; if (r_grant !== 2'b01) begin errors++; $display("FAIL ab_last_kept got %b exp 01", r_grant); end
    endtask

    initial begin
        RST_X = 1'b0;
        w_req = 2'b00;
        w_lock = 2'b00;
        w_done = 1'b0;
        w_busy = 1'b0;
        w_mode_is_cpu = 1'b1;
        w_next_mode_is_mc = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_lock();
        test_mode_gating();
        test_timeout();
        test_async_reset_abandon();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
